jtag_scan_master: RTL and testbench

- Host-side JTAG initiator that drives a boundary-scan chain through its TAP: generates TCK/TMS/TDI, walks the TAP state machine and captures TDO.
- Executes one command per Start: TAP reset, IR scan, or DR scan of 1..MAX_LEN bits.
- Sits between the on-chip test controller and the board scan chain, and exercises the chain's capture/shift/update cells from the driving end.

---
 rtl/jtag_scan_master.sv | 206 ++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
`default_nettype none
// ============================================================================
// Module      : jtag_scan_master
// Description : Host-side JTAG initiator. Generates TCK/TMS/TDI, walks the
//               TAP through reset, IR-scan or DR-scan sequences and collects
//               TDO into DataOut, one command per Start strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_scan_master #(
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = 6,
   parameter int DIV     = 2
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [1:0]         Cmd,
   input  logic [LEN_W-1:0]   Length,
   input  logic [MAX_LEN-1:0] DataIn,
   output logic [MAX_LEN-1:0] DataOut,
   output logic               Busy,
   output logic               Done,
   output logic               Error,
   output logic               TCK,
   output logic               TMS,
   output logic               TDI,
   input  logic               TDO
);

   localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int               HC_W      = $clog2(DIV) + 1;
   localparam logic [HC_W-1:0]  HALF_LAST = HC_W'(DIV - 1);
   localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] RST_LAST  = LEN_W'(5);
   localparam logic [1:0]       CMD_RESET = 2'b00;
   localparam logic [1:0]       CMD_IR    = 2'b01;
   localparam logic [1:0]       CMD_DR    = 2'b10;

   // Each non-idle state names the TAP state the chain sits in while the
   // current TCK pulse is issued; RST and SHIFT span several pulses.
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      RST     = 4'd1,
      RTI     = 4'd2,
      SEL_DR  = 4'd3,
      SEL_IR  = 4'd4,
      CAPTURE = 4'd5,
      SHIFT   = 4'd6,
      EXIT1   = 4'd7,
      UPDATE  = 4'd8
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [LEN_W-1:0]   bit_cnt;
   logic [LEN_W-1:0]   bit_cnt_nxt;
   logic [HC_W-1:0]    half_cnt;
   logic [MAX_LEN-1:0] data_q;
   logic [LEN_W-1:0]   len_q;
   logic               is_ir;

   logic               len_ok;
   logic               cmd_ok;
   logic               start_ok;
   logic               start_bad;
   logic               half_last;
   logic               pulse_end;
   logic               finish;
   logic               tms_nxt;
   logic               tdi_nxt;
   logic [LEN_W-1:0]   last_bit;

   assign len_ok    = (Length != '0) && (Length <= LEN_MAX);
   assign cmd_ok    = (Cmd == CMD_RESET) || (((Cmd == CMD_IR) || (Cmd == CMD_DR)) && len_ok);
   assign start_ok  = (state == IDLE) && Start && cmd_ok;
   assign start_bad = (state == IDLE) && Start && !cmd_ok;
   assign half_last = (half_cnt == HALF_LAST);
   assign pulse_end = (state != IDLE) && TCK && half_last;
   assign last_bit  = len_q - LEN_W'(1);
   assign Busy      = (state != IDLE);

   // State register and pulse/bit counter; reset abandons any command.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   // Next-state: advance one TAP step at the end of every TCK high phase.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      finish      = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_nxt   = (Cmd == CMD_RESET) ? RST : RTI;
               bit_cnt_nxt = '0;
            end
         end
         RST: begin
            if (pulse_end) begin
               if (bit_cnt == RST_LAST) begin
                  state_nxt = IDLE;
                  finish    = 1'b1;
               end else begin
                  bit_cnt_nxt = bit_cnt + LEN_W'(1);
               end
            end
         end
         RTI:     if (pulse_end) state_nxt = SEL_DR;
         SEL_DR:  if (pulse_end) state_nxt = is_ir ? SEL_IR : CAPTURE;
         SEL_IR:  if (pulse_end) state_nxt = CAPTURE;
         CAPTURE: begin
            if (pulse_end) begin
               state_nxt   = SHIFT;
               bit_cnt_nxt = '0;
            end
         end
         SHIFT: begin
            if (pulse_end) begin
               if (bit_cnt == last_bit) state_nxt = EXIT1;
               else                     bit_cnt_nxt = bit_cnt + LEN_W'(1);
            end
         end
         EXIT1:   if (pulse_end) state_nxt = UPDATE;
         UPDATE: begin
            if (pulse_end) begin
               state_nxt = IDLE;
               finish    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // TMS/TDI for the pulse about to start, derived from the step being entered.
   always_comb begin
      tms_nxt = 1'b0;
      tdi_nxt = 1'b0;
      case (state_nxt)
         RST:    tms_nxt = (bit_cnt_nxt < RST_LAST);
         RTI:    tms_nxt = 1'b1;
         SEL_DR: tms_nxt = is_ir;
         SHIFT: begin
            tms_nxt = (bit_cnt_nxt == last_bit);
            tdi_nxt = data_q[bit_cnt_nxt[IDX_W-1:0]];
         end
         EXIT1:  tms_nxt = 1'b1;
         default: ;
      endcase
   end

   // Datapath: command latch, TCK divider, TDO capture and completion flags.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         TCK      <= 1'b0;
         TMS      <= 1'b1;
         TDI      <= 1'b0;
         Done     <= 1'b0;
         Error    <= 1'b0;
         DataOut  <= '0;
         half_cnt <= '0;
         data_q   <= '0;
         len_q    <= '0;
         is_ir    <= 1'b0;
      end else begin
         Done  <= 1'b0;
         Error <= 1'b0;
         if (start_ok) begin
            data_q   <= DataIn;
            len_q    <= Length;
            is_ir    <= (Cmd == CMD_IR);
            DataOut  <= '0;
            TCK      <= 1'b0;
            half_cnt <= '0;
            TMS      <= tms_nxt;
            TDI      <= tdi_nxt;
         end else if (start_bad) begin
            Done  <= 1'b1;
            Error <= 1'b1;
         end else if (state != IDLE) begin
            if (half_last) begin
               half_cnt <= '0;
               TCK      <= ~TCK;
               if (!TCK && (state == SHIFT)) begin
                  DataOut[bit_cnt[IDX_W-1:0]] <= TDO;
               end
               if (TCK) begin
                  TMS  <= tms_nxt;
                  TDI  <= tdi_nxt;
                  Done <= finish;
               end
            end else begin
               half_cnt <= half_cnt + HC_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_scan_master
// Description : Self-checking bench for jtag_scan_master. A behavioural
//               16-state TAP with IR/DR shift chains sits on TCK/TMS/TDI/TDO;
//               expected pulse patterns are built from the command rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_scan_master;

   localparam int         MAX_LEN = 32;
   localparam int         LEN_W   = 6;
   localparam int         DIV     = 2;
   localparam logic [1:0] CMD_RST = 2'b00;
   localparam logic [1:0] CMD_IR  = 2'b01;
   localparam logic [1:0] CMD_DR  = 2'b10;
   localparam logic [1:0] CMD_BAD = 2'b11;

   logic               Clk = 1'b0;
   logic               Reset;
   logic               Start;
   logic [1:0]         Cmd;
   logic [LEN_W-1:0]   Length;
   logic [MAX_LEN-1:0] DataIn;
   logic [MAX_LEN-1:0] DataOut;
   logic               Busy;
   logic               Done;
   logic               Error;
   logic               TCK;
   logic               TMS;
   logic               TDI;
   logic               TDO;

   int checks   = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DIV(DIV)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Cmd(Cmd), .Length(Length),
      .DataIn(DataIn), .DataOut(DataOut), .Busy(Busy), .Done(Done),
      .Error(Error), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
   );

   // ---------------- behavioural scan chain (IEEE 1149.1 TAP) ----------------
   typedef enum logic [3:0] {
      TLR, RTI_S, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR,
      SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR
   } tap_t;

   tap_t        tap    = TLR;
   logic [31:0] dr_sr  = '0;
   logic [31:0] ir_sr  = '0;
   logic [31:0] dr_upd = '0;
   logic [31:0] ir_upd = '0;
   logic [31:0] dr_cap = '0;
   logic [31:0] ir_cap = '0;
   int          dr_len = 8;
   int          ir_len = 4;
   int          npulse = 0;
   logic        tms_log [0:4095];
   logic        tdi_log [0:4095];

   function automatic tap_t tap_next(input tap_t s, input logic m);
      case (s)
         TLR:   return m ? TLR  : RTI_S;
         RTI_S: return m ? SDS  : RTI_S;
         SDS:   return m ? SIS  : CDR;
         CDR:   return m ? E1DR : SHDR;
         SHDR:  return m ? E1DR : SHDR;
         E1DR:  return m ? UDR  : PDR;
         PDR:   return m ? E2DR : PDR;
         E2DR:  return m ? UDR  : SHDR;
         UDR:   return m ? SDS  : RTI_S;
         SIS:   return m ? TLR  : CIR;
         CIR:   return m ? E1IR : SHIR;
         SHIR:  return m ? E1IR : SHIR;
         E1IR:  return m ? UIR  : PIR;
         PIR:   return m ? E2IR : PIR;
         E2IR:  return m ? UIR  : SHIR;
         default: return m ? SDS : RTI_S;
      endcase
   endfunction

   assign TDO = (tap == SHIR) ? ir_sr[0] : dr_sr[0];

   always @(posedge TCK) begin
      tms_log[npulse % 4096] <= TMS;
      tdi_log[npulse % 4096] <= TDI;
      npulse <= npulse + 1;
      case (tap)
         CDR:  dr_sr  <= dr_cap;
         SHDR: dr_sr  <= (dr_sr >> 1) | (32'(TDI) << (dr_len - 1));
         UDR:  dr_upd <= dr_sr;
         CIR:  ir_sr  <= ir_cap;
         SHIR: ir_sr  <= (ir_sr >> 1) | (32'(TDI) << (ir_len - 1));
         UIR:  ir_upd <= ir_sr;
         default: ;
      endcase
      tap <= tap_next(tap, TMS);
   end

   // ---------------- pin-level monitors ----------------
   int   high_cyc  = 0;
   int   viol      = 0;
   logic prev_tms  = 1'b1;
   logic prev_tdi  = 1'b0;
   logic prev_tck  = 1'b0;
   logic prev_busy = 1'b0;
   logic rst_edge  = 1'b1;

   always @(posedge Clk) rst_edge <= Reset;

   always @(negedge Clk) begin
      if (TCK === 1'b1) high_cyc <= high_cyc + 1;
      if (((TMS !== prev_tms) || (TDI !== prev_tdi)) && !(prev_tck && !TCK) &&
          !(Busy && !prev_busy) && !rst_edge)
         viol <= viol + 1;
      prev_tms  <= TMS;
      prev_tdi  <= TDI;
      prev_tck  <= TCK;
      prev_busy <= Busy;
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] low_mask(input int n);
      logic [63:0] m;
      m = (64'd1 << n) - 64'd1;
      return m[31:0];
   endfunction

   // Issue one valid command and verify the whole pulse train and result.
   task automatic run_cmd(input logic [1:0] c, input int n, input logic [31:0] d,
                          input logic [31:0] cap, input bit disturb, input bit no_wait);
      int          base_p, base_h, cyc, exp_p, pre, got_p;
      logic [63:0] exp_tms, exp_tdi, got_tms, got_tdi;
      logic [31:0] msk;
      msk = low_mask(n);
      if (c == CMD_IR) begin
         ir_len = n;
         ir_cap = cap & msk;
      end else if (c == CMD_DR) begin
         dr_len = n;
         dr_cap = cap & msk;
      end
      if (!no_wait) @(negedge Clk);
      Start  = 1'b1;
      Cmd    = c;
      Length = LEN_W'(n);
      DataIn = d;
      base_p = npulse;
      base_h = high_cyc;
      @(negedge Clk);
      Start = 1'b0;
      cyc   = 1;
      check("busy_after_start", 64'(Busy), 64'd1);
      while (!Done && cyc < 400) begin
         if (disturb) begin
            Start  = 1'($urandom_range(0, 1));
            DataIn = $urandom;
            Cmd    = 2'($urandom);
            Length = LEN_W'($urandom);
         end
         @(negedge Clk);
         cyc++;
      end
      Start = 1'b0;

      exp_tms = '0;
      exp_tdi = '0;
      if (c == CMD_RST) begin
         exp_p   = 6;
         exp_tms = 64'h1F;
      end else begin
         pre        = (c == CMD_IR) ? 4 : 3;
         exp_p      = n + pre + 2;
         exp_tms[0] = 1'b1;
         if (c == CMD_IR) exp_tms[1] = 1'b1;
         exp_tms[pre + n - 1] = 1'b1;
         exp_tms[pre + n]     = 1'b1;
         for (int k = 0; k < n; k++) exp_tdi[pre + k] = d[k];
      end
      got_p   = npulse - base_p;
      got_tms = '0;
      got_tdi = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < got_p) begin
            got_tms[i] = tms_log[(base_p + i) % 4096];
            got_tdi[i] = tdi_log[(base_p + i) % 4096];
         end
      end

      check("done_seen",     64'(Done), 64'd1);
      check("error_clear",   64'(Error), 64'd0);
      check("busy_cleared",  64'(Busy), 64'd0);
      check("done_latency",  64'(cyc), 64'(2 * DIV * exp_p + 1));
      check("pulse_count",   64'(got_p), 64'(exp_p));
      check("tck_high_cyc",  64'(high_cyc - base_h), 64'(DIV * exp_p));
      check("tms_sequence",  got_tms, exp_tms);
      check("tdi_sequence",  got_tdi, exp_tdi);
      check("tap_parked",    64'(tap), 64'(RTI_S));
      check("tms_held_low",  64'(TMS), 64'd0);
      if (c == CMD_DR) begin
         check("dr_dataout", 64'(DataOut), 64'(cap & msk));
         check("dr_chain",   64'(dr_upd),  64'(d & msk));
      end else if (c == CMD_IR) begin
         check("ir_dataout", 64'(DataOut), 64'(cap & msk));
         check("ir_chain",   64'(ir_upd),  64'(d & msk));
      end
   endtask

   // Issue a command that must be rejected without touching the chain.
   task automatic run_reject(input logic [1:0] c, input int n);
      logic [31:0] prev_out;
      int          base_p;
      @(negedge Clk);
      prev_out = DataOut;
      base_p   = npulse;
      Start    = 1'b1;
      Cmd      = c;
      Length   = LEN_W'(n);
      DataIn   = $urandom;
      @(negedge Clk);
      Start = 1'b0;
      check("rej_done",    64'(Done), 64'd1);
      check("rej_error",   64'(Error), 64'd1);
      check("rej_busy",    64'(Busy), 64'd0);
      check("rej_dataout", 64'(DataOut), 64'(prev_out));
      @(negedge Clk);
      check("rej_done_1cyc", 64'(Done), 64'd0);
      check("rej_no_tck",    64'(npulse - base_p), 64'd0);
   endtask

   // ---------------- directed + randomized sequence ----------------
   initial begin
      int          base_p, wait_cyc, done_cnt, n;
      logic [1:0]  c;
      Reset  = 1'b1;
      Start  = 1'b0;
      Cmd    = 2'b00;
      Length = '0;
      DataIn = '0;
      repeat (3) @(negedge Clk);
      check("rst_tck",     64'(TCK), 64'd0);
      check("rst_tms",     64'(TMS), 64'd1);
      check("rst_tdi",     64'(TDI), 64'd0);
      check("rst_busy",    64'(Busy), 64'd0);
      check("rst_done",    64'(Done), 64'd0);
      check("rst_error",   64'(Error), 64'd0);
      check("rst_dataout", 64'(DataOut), 64'd0);
      Reset = 1'b0;

      run_cmd(CMD_RST, 0, 32'h0, 32'h0, 1'b0, 1'b0);
      run_cmd(CMD_DR, 8, 32'hA5, 32'h3C, 1'b0, 1'b0);
      @(negedge Clk);
      check("done_one_cycle", 64'(Done), 64'd0);
      run_cmd(CMD_IR, 4, 32'h6, 32'h1, 1'b0, 1'b0);
      run_cmd(CMD_DR, 1, $urandom, $urandom, 1'b0, 1'b0);
      run_cmd(CMD_DR, 32, $urandom, $urandom, 1'b0, 1'b0);

      run_reject(CMD_DR, 0);
      run_reject(CMD_DR, 33);
      run_reject(CMD_IR, 0);
      run_reject(CMD_BAD, 8);

      // Start while busy / DataIn churn, then back-to-back Start in Done cycle.
      run_cmd(CMD_DR, 12, $urandom, $urandom, 1'b1, 1'b0);
      run_cmd(CMD_IR, 5, $urandom, $urandom, 1'b0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         c = ($urandom_range(0, 1) == 0) ? CMD_IR : CMD_DR;
         n = $urandom_range(1, MAX_LEN);
         run_cmd(c, n, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      end

      // Abort with reset while shift bit 3 is in its low phase.
      dr_len = 8;
      dr_cap = 32'h5A;
      @(negedge Clk);
      Start  = 1'b1;
      Cmd    = CMD_DR;
      Length = LEN_W'(8);
      DataIn = 32'hC3;
      base_p = npulse;
      @(negedge Clk);
      Start    = 1'b0;
      wait_cyc = 0;
      while (!((npulse - base_p) == 6 && TCK == 1'b0) && wait_cyc < 200) begin
         @(negedge Clk);
         wait_cyc++;
      end
      check("abort_reached_bit3", 64'(Busy), 64'd1);
      Reset = 1'b1;
      @(negedge Clk);
      check("abort_tck",  64'(TCK), 64'd0);
      check("abort_tms",  64'(TMS), 64'd1);
      check("abort_busy", 64'(Busy), 64'd0);
      check("abort_done", 64'(Done), 64'd0);
      Reset    = 1'b0;
      done_cnt = 0;
      repeat (20) begin
         @(negedge Clk);
         if (Done) done_cnt++;
      end
      check("abort_no_done", 64'(done_cnt), 64'd0);
      run_cmd(CMD_RST, 0, 32'h0, 32'h0, 1'b0, 1'b0);
      run_cmd(CMD_DR, 8, $urandom, $urandom, 1'b0, 1'b0);

      @(negedge Clk);
      check("tms_tdi_change_timing", 64'(viol), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
